// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one pipelined multiplier between two requesters.
// Define MUL_SHARE_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead.
module mul_share_arb #(
   parameter int unsigned XLEN = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [1:0]           req_valid_i,
   output logic [1:0]           req_ready_o,
   input  logic [1:0][2:0]      req_funct3_i,
   input  logic [1:0][XLEN-1:0] req_rs1_i,
   input  logic [1:0][XLEN-1:0] req_rs2_i,
   output logic [1:0]           rsp_valid_o,
   input  logic [1:0]           rsp_ready_i,
   output logic [XLEN-1:0]      rsp_data_o,
   output logic [2:0]           mul_funct3_o,
   output logic [XLEN-1:0]      mul_rs1_o,
   output logic [XLEN-1:0]      mul_rs2_o,
   output logic                 mul_stall_o,
   input  logic [XLEN-1:0]      mul_result_i
);

   logic inflight_q;
   logic owner_q;
   logic rr_q;

   logic drain;
   logic can_issue;
   logic grant_any;
   logic grant_id;

   // Issue decision: a slot opens when the multiplier is empty or its result leaves this cycle.
   always_comb begin
      drain     = inflight_q & rsp_ready_i[owner_q];
      can_issue = ~inflight_q | drain;
      grant_any = reset_n & can_issue & (|req_valid_i);
      grant_id  = req_valid_i[rr_q] ? rr_q : ~rr_q;
   end

   // Request side: one-hot ready plus operand steering; idle slots issue zero bubbles.
   always_comb begin
      req_ready_o  = 2'b00;
      mul_funct3_o = 3'd0;
      mul_rs1_o    = '0;
      mul_rs2_o    = '0;
      if (grant_any) begin
         req_ready_o[grant_id] = 1'b1;
         mul_funct3_o          = req_funct3_i[grant_id];
         mul_rs1_o             = req_rs1_i[grant_id];
         mul_rs2_o             = req_rs2_i[grant_id];
      end
   end

   // Response side: freeze the multiplier while the owner holds off its result.
   always_comb begin
      rsp_valid_o          = 2'b00;
      rsp_valid_o[owner_q] = inflight_q;
      rsp_data_o           = inflight_q ? mul_result_i : '0;
      mul_stall_o          = inflight_q & ~drain;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight_q <= 1'b0;
         owner_q    <= 1'b0;
         rr_q       <= 1'b0;
      end else if (grant_any) begin
         inflight_q <= 1'b1;
         owner_q    <= grant_id;
`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
         rr_q       <= 1'b0;
`else
         rr_q       <= ~grant_id;
`endif
      end else if (drain) begin
         inflight_q <= 1'b0;
      end
   end

endmodule
